// File: rtl/obuf_loop_ctrl.sv
// obuf_loop_ctrl: walks a configured loop nest (entry 0 innermost) and emits
// loop_enter / loop_index_valid / loop_exit events plus the obuf address of
// each innermost iteration. Optional address path: OBUF_LOOP_CTRL_ADDR_EN.
module obuf_loop_ctrl #(
  parameter int LOOP_ID_W     = 5,
  parameter int LOOP_ITER_W   = 16,
  parameter int ADDR_STRIDE_W = 16,
  parameter int OBUF_ADDR_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     done,
  input  logic                     cfg_v,
  input  logic [LOOP_ITER_W-1:0]   cfg_loop_iter,
  input  logic [ADDR_STRIDE_W-1:0] cfg_stride,
  input  logic [OBUF_ADDR_W-1:0]   obuf_base_addr,
  input  logic                     stall,
  output logic [ADDR_STRIDE_W-1:0] obuf_stride,
  output logic                     obuf_stride_v,
  output logic                     loop_enter,
  output logic                     loop_exit,
  output logic                     loop_index_valid,
  output logic                     loop_last_iter,
  output logic                     loop_stall,
  output logic [LOOP_ID_W-1:0]     loop_index,
  output logic [OBUF_ADDR_W-1:0]   obuf_addr
);

  localparam int NL = 2 ** LOOP_ID_W;
  localparam logic [LOOP_ID_W:0] NL_CNT = (LOOP_ID_W + 1)'(NL);

  typedef enum logic [2:0] {S_IDLE, S_ENTER, S_BUSY, S_EXIT, S_DONE} state_t;

  state_t                   r_state;
  logic [LOOP_ID_W:0]       r_num;
  logic [LOOP_ID_W-1:0]     r_idx;
  logic [LOOP_ITER_W-1:0]   r_max [NL];
  logic [LOOP_ITER_W-1:0]   r_cnt [NL];
  logic                     r_stride_v;
  logic [ADDR_STRIDE_W-1:0] r_stride_o;

  logic                 w_active, w_go, w_cfg_acc, w_start_acc;
  logic                 w_last0, w_outer, w_pwrap;
  logic [LOOP_ID_W-1:0] w_parent, w_wr_idx;

  assign w_active    = (r_state == S_ENTER) || (r_state == S_BUSY) || (r_state == S_EXIT);
  assign w_go        = w_active && !stall;
  assign w_cfg_acc   = cfg_v && (r_state == S_IDLE) && (r_num != NL_CNT);
  assign w_start_acc = start && (r_state == S_IDLE) && (r_num != '0);
  assign w_wr_idx    = r_num[LOOP_ID_W-1:0];
  assign w_parent    = r_idx + 1'b1;
  assign w_last0     = (r_cnt[0] == r_max[0]);
  // outermost loop reached: nothing left to carry into
  assign w_outer     = ({1'b0, r_idx} == (r_num - 1'b1));
  assign w_pwrap     = (r_cnt[w_parent] == r_max[w_parent]);

  // Iteration-max table; contents are only meaningful below r_num
  always_ff @(posedge clk) begin
    if (w_cfg_acc) r_max[w_wr_idx] <= cfg_loop_iter;
  end

  // Control FSM: table fill, nest walk and per-loop iteration counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_num      <= '0;
      r_idx      <= '0;
      r_stride_v <= 1'b0;
      r_stride_o <= '0;
      for (int i = 0; i < NL; i++) r_cnt[i] <= '0;
    end else begin
      r_stride_v <= w_cfg_acc;
      if (w_cfg_acc) begin
        r_stride_o <= cfg_stride;
        r_num      <= r_num + 1'b1;
      end
      case (r_state)
        S_IDLE: if (w_start_acc) begin
          r_state <= S_ENTER;
          r_idx   <= LOOP_ID_W'(r_num - 1'b1);
          for (int i = 0; i < NL; i++) r_cnt[i] <= '0;
        end
        S_ENTER: if (!stall) begin
          if (r_idx == '0) r_state <= S_BUSY;
          else             r_idx   <= r_idx - 1'b1;
        end
        S_BUSY: if (!stall) begin
          if (w_last0) begin
            r_cnt[0] <= '0;
            r_idx    <= '0;
            r_state  <= S_EXIT;
          end else begin
            r_cnt[0] <= r_cnt[0] + 1'b1;
          end
        end
        S_EXIT: if (!stall) begin
          if (w_outer) begin
            r_state <= S_DONE;
          end else if (w_pwrap) begin
            r_cnt[w_parent] <= '0;
            r_idx           <= w_parent;
          end else begin
            // re-enter from the parent's child, which is the current idx
            r_cnt[w_parent] <= r_cnt[w_parent] + 1'b1;
            r_state         <= S_ENTER;
          end
        end
        S_DONE: begin
          r_num   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef OBUF_LOOP_CTRL_ADDR_EN
  logic [ADDR_STRIDE_W-1:0] r_stride [NL];
  logic [OBUF_ADDR_W-1:0]   r_base   [NL];
  logic [OBUF_ADDR_W-1:0]   r_addr;
  logic [OBUF_ADDR_W-1:0]   w_step0, w_pstep;
  logic                     w_pstep_en;

  assign w_step0    = r_addr + OBUF_ADDR_W'(r_stride[0]);
  assign w_pstep    = r_base[w_parent] + OBUF_ADDR_W'(r_stride[w_parent]);
  assign w_pstep_en = (r_state == S_EXIT) && !stall && !w_outer && !w_pwrap;

  // Stride table, filled alongside the iteration-max table
  always_ff @(posedge clk) begin
    if (w_cfg_acc) r_stride[w_wr_idx] <= cfg_stride;
  end

  // Per-loop base of the current iteration; advanced in place so a parent
  // step is one add instead of base + cnt * stride
  always_ff @(posedge clk) begin
    if ((r_state == S_ENTER) && !stall) r_base[r_idx]    <= r_addr;
    else if (w_pstep_en)                r_base[w_parent] <= w_pstep;
  end

  // Current innermost address
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       r_addr <= '0;
    else if (w_start_acc)                            r_addr <= obuf_base_addr;
    else if ((r_state == S_BUSY) && !stall && !w_last0) r_addr <= w_step0;
    else if (w_pstep_en)                             r_addr <= w_pstep;
  end

  assign obuf_addr = r_addr;
`else
  logic w_unused_base;
  assign w_unused_base = ^obuf_base_addr;
  assign obuf_addr     = '0;
`endif

  assign loop_enter       = (r_state == S_ENTER) && !stall;
  assign loop_index_valid = (r_state == S_BUSY) && !stall;
  assign loop_exit        = (r_state == S_EXIT) && !stall;
  assign loop_last_iter   = (loop_index_valid && w_last0) || loop_exit;
  assign loop_stall       = stall && w_active;
  assign loop_index       = w_active ? r_idx : '0;
  assign done             = (r_state == S_DONE);
  assign obuf_stride      = r_stride_o;
  assign obuf_stride_v    = r_stride_v;

endmodule
